// File: rtl/tom_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tom_arith_pkg
//  Purpose  : Shared types and constants for the TOM ARITH normalisation path
//  Revision : 1.0 - initial release
// ============================================================================
package tom_arith_pkg;

    // Scan controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // Bit position the operand MSB is moved to
    localparam int TGT_BIT   = 23;

    // Reachable range of the signed normalisation count
    localparam int NORMI_MIN = -23;
    localparam int NORMI_MAX = 8;

endpackage : tom_arith_pkg
`default_nettype wire

// File: rtl/nib_prio4.sv
`default_nettype none
// ============================================================================
//  Module   : nib_prio4
//  Purpose  : 4-bit priority encoder; reports the highest set bit position
//  Revision : 1.0 - initial release
// ============================================================================
module nib_prio4 (
    input  logic [3:0] nib,
    output logic [1:0] pos,
    output logic       valid
);

    // Highest set bit wins; valid is low for an all-zero nibble
    always_comb begin
        pos   = 2'd0;
        valid = 1'b1;
        casez (nib)
            4'b1???: pos = 2'd3;
            4'b01??: pos = 2'd2;
            4'b001?: pos = 2'd1;
            4'b0001: pos = 2'd0;
            default: valid = 1'b0;
        endcase
    end

endmodule : nib_prio4
`default_nettype wire

// File: rtl/normi_scan.sv
`default_nettype none
// ============================================================================
//  Module   : normi_scan
//  Purpose  : Multi-cycle normalisation count. Scans the operand one nibble
//             per cycle from the top, then returns the signed count that puts
//             the MSB at TGT_BIT together with the already-normalised operand.
//  Revision : 1.0 - initial release
// ============================================================================
module normi_scan
    import tom_arith_pkg::*;
#(
    parameter int TGT_BIT = tom_arith_pkg::TGT_BIT,
    parameter int NIB     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        start_ready,
    input  logic [31:0] srcd,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] normi,
    output logic [31:0] norm_q,
    output logic        zero_n
);

    scan_state_t        state;
    logic [31:0]        opnd;
    logic [2:0]         k;

    logic [NIB-1:0]     nib_bits;
    logic [1:0]         nib_pos;
    logic               nib_hit;
    logic [4:0]         msb_idx;
    logic signed [5:0]  cnt;
    logic [5:0]         shl_amt;
    logic [5:0]         shr_amt;
    logic [31:0]        shifted;

    // Nibble under test this cycle: bits 4k+3..4k
    assign nib_bits = opnd[{k, 2'b00} +: NIB];

    nib_prio4 u_prio (
        .nib   (nib_bits),
        .pos   (nib_pos),
        .valid (nib_hit)
    );

    // Six-bit signed count; the scan only ever yields -23..+8 so it never wraps
    assign msb_idx = {k, nib_pos};
    assign cnt     = $signed({1'b0, msb_idx}) - $signed(6'(TGT_BIT));
    assign shl_amt = 6'(-cnt);
    assign shr_amt = $unsigned(cnt);

    // Single shift towards TGT_BIT, zero-filled in either direction
    always_comb begin
        shifted = 32'd0;
        if (cnt[5]) begin
            shifted = opnd << shl_amt;
        end else begin
            shifted = opnd >> shr_amt;
        end
    end

    // Acceptance is decoded from state only
    assign start_ready = (state == ST_IDLE);

    // Scan controller with registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            opnd      <= 32'd0;
            k         <= 3'd7;
            res_valid <= 1'b0;
            normi     <= 32'd0;
            norm_q    <= 32'd0;
            zero_n    <= 1'b1;
        end else if (flush) begin
            // Abort: drop any pending result but keep the last outputs
            state     <= ST_IDLE;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opnd  <= srcd;
                        k     <= 3'd7;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (nib_hit) begin
                        normi     <= {{26{cnt[5]}}, cnt};
                        norm_q    <= shifted;
                        zero_n    <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else if (k == 3'd0) begin
                        normi     <= 32'd0;
                        norm_q    <= 32'd0;
                        zero_n    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        k <= k - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : normi_scan
`default_nettype wire

// File: tb/tb_normi_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_normi_scan
//  Purpose  : Directed self-checking bench for normi_scan
//  Revision : 1.0 - initial release
// ============================================================================
module tb_normi_scan;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_ready;
    logic [31:0] srcd;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] normi;
    logic [31:0] norm_q;
    logic        zero_n;

    int errors = 0;
    int checks = 0;

    normi_scan dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_ready (start_ready),
        .srcd        (srcd),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .normi       (normi),
        .norm_q      (norm_q),
        .zero_n      (zero_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges after acceptance until res_valid; -1 on timeout
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!res_valid) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; srcd = 32'd0; flush = 1'b0; res_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (normi !== 32'd0) begin errors++; $display("FAIL reset_normi got=%h exp=0", normi); end
        checks++; if (norm_q !== 32'd0) begin errors++; $display("FAIL reset_norm_q got=%h exp=0", norm_q); end
        checks++; if (zero_n !== 1'b1) begin errors++; $display("FAIL reset_zero_n got=%b exp=1", zero_n); end
    endtask

    // Table: operand, edges to res_valid after accept, normi, norm_q, zero_n
    task automatic test_scan_vectors();
        logic [31:0] v_d [7];
        int          v_l [7];
        logic [31:0] v_n [7];
        logic [31:0] v_q [7];
        logic        v_z [7];
        int          lat;
        v_d[0] = 32'h8000_0000; v_l[0] = 1; v_n[0] = 32'h0000_0008; v_q[0] = 32'h0080_0000; v_z[0] = 1'b1;
        v_d[1] = 32'h0080_0000; v_l[1] = 3; v_n[1] = 32'h0000_0000; v_q[1] = 32'h0080_0000; v_z[1] = 1'b1;
        v_d[2] = 32'h0000_0001; v_l[2] = 8; v_n[2] = 32'hFFFF_FFE9; v_q[2] = 32'h0080_0000; v_z[2] = 1'b1;
        v_d[3] = 32'h0000_0000; v_l[3] = 8; v_n[3] = 32'h0000_0000; v_q[3] = 32'h0000_0000; v_z[3] = 1'b0;
        v_d[4] = 32'h0000_F000; v_l[4] = 5; v_n[4] = 32'hFFFF_FFF8; v_q[4] = 32'h00F0_0000; v_z[4] = 1'b1;
        v_d[5] = 32'h0000_0300; v_l[5] = 6; v_n[5] = 32'hFFFF_FFF2; v_q[5] = 32'h00C0_0000; v_z[5] = 1'b1;
        v_d[6] = 32'h0A00_0000; v_l[6] = 2; v_n[6] = 32'h0000_0004; v_q[6] = 32'h00A0_0000; v_z[6] = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            srcd = v_d[i]; start = 1'b1;
            tick();
            start = 1'b0; srcd = 32'hDEAD_BEEF;
            checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL scan_busy[%0d] start_ready got=%b exp=0", i, start_ready); end
            wait_valid(lat);
            checks++; if (lat != v_l[i]) begin errors++; $display("FAIL scan_latency[%0d] got=%0d exp=%0d", i, lat, v_l[i]); end
            checks++; if (normi !== v_n[i]) begin errors++; $display("FAIL scan_normi[%0d] got=%h exp=%h", i, normi, v_n[i]); end
            checks++; if (norm_q !== v_q[i]) begin errors++; $display("FAIL scan_norm_q[%0d] got=%h exp=%h", i, norm_q, v_q[i]); end
            checks++; if (zero_n !== v_z[i]) begin errors++; $display("FAIL scan_zero_n[%0d] got=%b exp=%b", i, zero_n, v_z[i]); end
            tick();
            checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL scan_handshake[%0d] got valid=%b ready=%b exp valid=0 ready=1", i, res_valid, start_ready); end
        end
    endtask

    // Result held under backpressure; start ignored until after handshake
    task automatic test_backpressure();
        int lat;
        res_ready = 1'b0;
        srcd = 32'h0001_2345; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; srcd = 32'h8000_0000;
            tick();
            checks++; if (res_valid !== 1'b1 || start_ready !== 1'b0 || normi !== 32'hFFFF_FFF9 || norm_q !== 32'h0091_A280)
                begin errors++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b normi=%h q=%h exp 1 0 fffffff9 0091a280", i, res_valid, start_ready, normi, norm_q); end
        end
        // Handshake cycle with start high: must not be taken
        res_ready = 1'b1; start = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b exp 0 1", res_valid, start_ready); end
        start = 1'b0;
        tick();
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept got ready=%b exp=1", start_ready); end
    endtask

    // Flush mid-scan: no result, outputs retain previous values, restart ok
    task automatic test_flush();
        int lat;
        int seen;
        res_ready = 1'b1; seen = 0;
        srcd = 32'h0000_0001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        if (res_valid) seen++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (res_valid) seen++;
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got ready=%b exp=1", start_ready); end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
        checks++; if (normi !== 32'hFFFF_FFF9 || norm_q !== 32'h0091_A280) begin errors++; $display("FAIL flush_retain got normi=%h q=%h exp fffffff9 0091a280", normi, norm_q); end
        srcd = 32'h8000_0000; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 1 || normi !== 32'h0000_0008 || norm_q !== 32'h0080_0000) begin errors++; $display("FAIL flush_restart got lat=%0d normi=%h q=%h exp 1 00000008 00800000", lat, normi, norm_q); end
        tick();
    endtask

    // Reset while a result is pending and start is high
    task automatic test_reset_in_done();
        int lat;
        res_ready = 1'b0;
        srcd = 32'h0000_F000; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL rd_latency got=%0d exp=5", lat); end
        reset = 1'b1; start = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        checks++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL rd_ctrl got valid=%b ready=%b exp 0 1", res_valid, start_ready); end
        checks++; if (normi !== 32'd0 || norm_q !== 32'd0 || zero_n !== 1'b1) begin errors++; $display("FAIL rd_outputs got normi=%h q=%h zn=%b exp 0 0 1", normi, norm_q, zero_n); end
        tick();
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rd_idle got ready=%b exp=1", start_ready); end
    endtask

    initial begin
        test_reset();
        test_scan_vectors();
        test_backpressure();
        test_flush();
        test_reset_in_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_normi_scan
`default_nettype wire
